column_scanner: RTL and testbench

COLUMN_SCANNER -- requirements
Module: column_scanner

---
 rtl/column_scanner.sv | 134 +++++++++++++
 tb/tb_column_scanner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/column_scanner.sv
// Column scanner: reports the positions of set bits in a row, lowest first, at or after start_pos.
// Latency: first result one cycle after load acceptance; then one result per accepted handshake.
// Backpressure: results hold while out_ready=0; loads are taken only in IDLE or on the final handshake.
// Optional feature macro: COLUMN_SCANNER_COUNT_EN adds the 'remaining' popcount output.
module column_scanner #(
  parameter int WIDTH = 8,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [0:WIDTH-1] row,
  input  logic [POS_W-1:0] start_pos,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] column,
  output logic             last,
  output logic             none
`ifdef COLUMN_SCANNER_COUNT_EN
  , output logic [POS_W:0] remaining
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, EMPTY} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  // mask_q[i] holds position i (row index i); bit 0 is the leftmost column.
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] row_masked;
  logic [WIDTH-1:0] mask_rest;
  logic [POS_W-1:0] low_pos;
  logic             single;
  logic             hs;
  logic             accept;

  // Clear every position below start_pos in the offered row; start_pos >= WIDTH clears all.
  always_comb begin
    row_masked = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= int'(start_pos)) row_masked[i] = row[i];
    end
  end

  // Priority search for the lowest set position; the last write in the loop wins.
  always_comb begin
    low_pos = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_q[i]) low_pos = POS_W'(i);
    end
  end

  // Mask with its lowest set bit removed; empty remainder means exactly one bit left.
  always_comb begin
    mask_rest = mask_q & (mask_q - ONE);
    single    = (mask_q != '0) && (mask_rest == '0);
  end

  // Outputs and next state, decoded from registered state only (no path from row to outputs).
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    out_valid  = 1'b0;
    column     = '0;
    last       = 1'b0;
    none       = 1'b0;
    load_ready = 1'b0;
    hs         = 1'b0;
    accept     = 1'b0;

    case (state_q)
      SCAN: begin
        out_valid = 1'b1;
        column    = low_pos;
        last      = single;
      end
      EMPTY: begin
        out_valid = 1'b1;
        none      = 1'b1;
        last      = 1'b1;
      end
      default: ;
    endcase

    hs         = out_valid && out_ready;
    load_ready = (state_q == IDLE) || (hs && last);
    accept     = load_valid && load_ready;

    if (flush) begin
      // Flush beats both handshakes; a load offered now is dropped.
      state_d = IDLE;
      mask_d  = '0;
    end else begin
      if (hs && !last) mask_d = mask_rest;
      if (hs && last) begin
        state_d = IDLE;
        mask_d  = '0;
      end
      if (accept) begin
        mask_d  = row_masked;
        state_d = (row_masked != '0) ? SCAN : EMPTY;
      end
    end
  end

  // State and mask registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

`ifdef COLUMN_SCANNER_COUNT_EN
  // Popcount of the live mask, presented bit included; zero outside SCAN.
  always_comb begin
    remaining = '0;
    if (state_q == SCAN) begin
      for (int i = 0; i < WIDTH; i++) begin
        remaining = remaining + (POS_W + 1)'(mask_q[i]);
      end
    end
  end
`else
  // Count output not built in this configuration.
`endif

endmodule

// File: tb/tb_column_scanner.sv
// Scoreboard bench for column_scanner: directed scenarios then randomized traffic.
// The reference model expands each accepted row into its list of expected results.
// A negedge monitor compares every presented result against the queue head.
module tb_column_scanner;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, load_valid, load_ready, flush, out_valid, out_ready, last, none;
  logic [0:7] row;
  logic [2:0] start_pos, column;
`ifdef COLUMN_SCANNER_COUNT_EN
  logic [3:0] remaining;
`endif

  logic       w6_load_valid, w6_load_ready, w6_out_valid, w6_last, w6_none;
  logic [0:5] w6_row;
  logic [2:0] w6_start_pos, w6_column;
`ifdef COLUMN_SCANNER_COUNT_EN
  logic [3:0] w6_remaining;
`endif

  column_scanner #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .row(row), .start_pos(start_pos), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .column(column), .last(last), .none(none)
`ifdef COLUMN_SCANNER_COUNT_EN
    , .remaining(remaining)
`endif
  );

  column_scanner #(.WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .load_valid(w6_load_valid), .load_ready(w6_load_ready),
    .row(w6_row), .start_pos(w6_start_pos), .flush(1'b0), .out_valid(w6_out_valid),
    .out_ready(1'b1), .column(w6_column), .last(w6_last), .none(w6_none)
`ifdef COLUMN_SCANNER_COUNT_EN
    , .remaining(w6_remaining)
`endif
  );

  typedef struct {
    int col;
    bit lst;
    bit nne;
    int rem;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  bit   model_rdy = 1'b1;
  bit   exp_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list the eligible set positions, then emit one result per position.
  task automatic push_row(input logic [0:7] r, input int sp);
    int   pos[$];
    exp_t e;
    for (int p = 0; p < 8; p++) if (r[p] === 1'b1 && p >= sp) pos.push_back(p);
    if (pos.size() == 0) begin
      e = '{0, 1'b1, 1'b1, 0};
      q.push_back(e);
    end else begin
      for (int k = 0; k < pos.size(); k++) begin
        e = '{pos[k], (k == pos.size() - 1), 1'b0, pos.size() - k};
        q.push_back(e);
      end
    end
  endtask

  // Monitor: compares outputs every cycle and retires entries on handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_rdy = (q.size() == 0);
      if (q.size() != 0) begin
        if (out_ready && q[0].lst) exp_rdy = 1'b1;
      end
      model_rdy = exp_rdy;
      chk("load_ready", 32'(load_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("column", 32'(column), q[0].col);
        chk("last", 32'(last), 32'(q[0].lst));
        chk("none", 32'(none), 32'(q[0].nne));
`ifdef COLUMN_SCANNER_COUNT_EN
        chk("remaining", 32'(remaining), q[0].nne ? 0 : q[0].rem);
`endif
      end else begin
        chk("idle_column", 32'(column), 0);
        chk("idle_last", 32'(last), 0);
        chk("idle_none", 32'(none), 0);
`ifdef COLUMN_SCANNER_COUNT_EN
        chk("idle_remaining", 32'(remaining), 0);
`endif
      end
      if (flush) q.delete();
      else if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        popped++;
      end
    end
  end

  // One clock of stimulus; the expected results are queued when the load is accepted.
  task automatic cyc(input logic lv, input logic [0:7] r, input logic [2:0] sp,
                     input logic fl, input logic ordy, input logic rn);
    load_valid = lv;
    row        = r;
    start_pos  = sp;
    flush      = fl;
    out_ready  = ordy;
    rst_n      = rn;
    @(negedge clk);
    #1;
    if (rn && !fl && lv && model_rdy) push_row(r, int'(sp));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 3'd0, 1'b0, ordy, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; row = '0; start_pos = '0; flush = 1'b0; out_ready = 1'b0;
    w6_load_valid = 1'b0; w6_row = '0; w6_start_pos = '0;
    @(posedge clk);
    #1;
    chk("w6_reset_load_ready", 32'(w6_load_ready), 1);

    // Narrow instance: start_pos beyond the row width must report empty.
    w6_load_valid = 1'b1; w6_row = 6'b101011; w6_start_pos = 3'd7;
    idle(1, 1'b1);
    w6_load_valid = 1'b0;
    chk("w6_out_valid", 32'(w6_out_valid), 1);
    chk("w6_none", 32'(w6_none), 1);
    chk("w6_last", 32'(w6_last), 1);
    chk("w6_column", 32'(w6_column), 0);

    // Three results in consecutive cycles.
    cyc(1'b1, 8'b10010010, 3'd0, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    // start_pos masks off the lower bits.
    cyc(1'b1, 8'b10010010, 3'd4, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    // Stall holds the presented result.
    cyc(1'b1, 8'b00001111, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(4, 1'b1);
    // Empty row.
    cyc(1'b1, 8'b00000000, 3'd0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    // Flush after the first handshake.
    cyc(1'b1, 8'b11000001, 3'd0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    cyc(1'b1, 8'b11111111, 3'd0, 1'b1, 1'b1, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_load_ready", 32'(load_ready), 1);
    idle(3, 1'b1);
    // Reset mid-scan.
    cyc(1'b1, 8'b11000001, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_load_ready", 32'(load_ready), 1);
    chk("rst_column", 32'(column), 0);
    // Count scenario.
    cyc(1'b1, 8'b10110000, 3'd0, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic including back-to-back loads, stalls, flushes and resets.
    for (int n = 0; n < 2000; n++) begin
      logic [0:7] r;
      logic [2:0] sp;
      r  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      sp = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      cyc(1'($urandom), r, sp, ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
    end

    idle(12, 1'b1);
    chk("drained", 32'(q.size()), 0);
    chk("results_seen", 32'(popped > 200), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
